fp_norm_round: RTL

Multi-cycle normalize-and-round stage directly downstream of the single-precision FP adder datapath. It accepts the adder's raw result: sign, pre-normalization exponent, and a 27-bit extended mantissa with carry, hidden, fraction, guard and sticky bits. It produces a normalized, round-to-nearest-even IEEE-754 binary32 word. Transfers use valid/ready on both sides, and the block holds one operation at a time.

---
 rtl/fp_norm_round_if.sv | 23 ++
 rtl/fp_norm_round.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fp_norm_round_if.sv
// Handshake and payload bundle between the FP adder, the normalize/round stage and its consumer.
interface fp_norm_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_inexact
  );
endinterface

// File: rtl/fp_norm_round.sv
// Multi-cycle normalize and round-to-nearest-even stage producing a binary32 word.
// One operation in flight; one bit of left shift per SHIFT cycle.
module fp_norm_round (
  input logic             clk,
  input logic             rst,
  fp_norm_round_if.slave  bus
);

  localparam int unsigned EXP_W  = 9;
  localparam int unsigned MANT_W = 27;
  localparam int unsigned SIG_W  = 25;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t              state;
  logic                sign;
  logic [EXP_W-1:0]    exp;
  logic [MANT_W-1:0]   mant;
  logic                out_valid;
  logic [31:0]         out_result;
  logic                out_overflow;
  logic                out_inexact;

  logic                lsb_c;
  logic                g_c;
  logic                s_c;
  logic                inc_c;
  logic                subnormal_c;
  logic [SIG_W-1:0]    m24_c;
  logic [EXP_W-1:0]    exp_r_c;
  logic [7:0]          exp_field_c;
  logic                ovf_c;

  // Rounding datapath, consumed only in ROUND
  always_comb begin
    lsb_c       = mant[2];
    g_c         = mant[1];
    s_c         = mant[0];
    inc_c       = g_c & (s_c | lsb_c);
    subnormal_c = ~mant[25];
    m24_c       = {1'b0, mant[25:2]} + SIG_W'(inc_c);
    exp_r_c     = m24_c[24] ? (exp + EXP_W'(1)) : exp;
    if (subnormal_c) begin
      exp_field_c = m24_c[23] ? 8'd1 : 8'd0;
    end else begin
      exp_field_c = exp_r_c[7:0];
    end
    ovf_c = ~subnormal_c & (exp_r_c >= EXP_W'(255));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sign         <= 1'b0;
      exp          <= '0;
      mant         <= '0;
      out_valid    <= 1'b0;
      out_result   <= 32'h0;
      out_overflow <= 1'b0;
      out_inexact  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign <= bus.in_sign;
            exp  <= {1'b0, bus.in_exp};
            mant <= bus.in_mant;
            // Inf/NaN bypass the datapath untouched
            if (bus.in_exp == 8'hFF) begin
              out_result   <= {bus.in_sign, 8'hFF, bus.in_mant[24:2]};
              out_overflow <= 1'b0;
              out_inexact  <= 1'b0;
              out_valid    <= 1'b1;
              state        <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (mant == '0) begin
            out_result   <= {sign, 31'h0};
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (mant[26]) begin
            mant  <= {1'b0, mant[26:2], mant[1] | mant[0]};
            exp   <= exp + EXP_W'(1);
            state <= ROUND;
          end else if (!mant[25] && (exp > EXP_W'(1))) begin
            mant <= {mant[25:0], 1'b0};
            exp  <= exp - EXP_W'(1);
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (ovf_c) begin
            out_result   <= {sign, 8'hFF, 23'h0};
            out_overflow <= 1'b1;
          end else begin
            out_result   <= {sign, exp_field_c, m24_c[22:0]};
            out_overflow <= 1'b0;
          end
          out_inexact <= g_c | s_c;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = out_valid;
  assign bus.out_result   = out_result;
  assign bus.out_overflow = out_overflow;
  assign bus.out_inexact  = out_inexact;

endmodule
